// File: rtl/mem_bridge_pkg.sv
// Shared memory-access datatypes: RISC-V load/store size encoding and the
// alignment/legality rule used by the decoder and the memory bridge.
package mem_bridge_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_t;

    // Unsigned sizes only make sense for loads; stores of BU/HU are illegal.
    function automatic logic access_legal(input logic [2:0] size,
                                          input logic [1:0] addr_lo,
                                          input logic       is_write);
        case (mem_size_t'(size))
            MEM_B:   access_legal = 1'b1;
            MEM_H:   access_legal = !addr_lo[0];
            MEM_W:   access_legal = (addr_lo == 2'b00);
            MEM_BU:  access_legal = !is_write;
            MEM_HU:  access_legal = !is_write && !addr_lo[0];
            default: access_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Load-data extraction: picks the byte/halfword lane from a bus word and
// sign- or zero-extends it according to the access size.
module mem_lane_align
    import mem_bridge_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[7:0];
        case (addr_lo)
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            2'd3:    byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = rdata;
        case (mem_size_t'(size))
            MEM_B:   data = {{24{byte_v[7]}}, byte_v};
            MEM_BU:  data = {24'd0, byte_v};
            MEM_H:   data = {{16{half_v[15]}}, half_v};
            MEM_HU:  data = {16'd0, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_bridge.sv
// Bridge from the multicycle core's pulse/MAR/MDR memory interface to a
// word-wide valid/ready bus, with alignment checks and a bus timeout.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_size,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_REQ     = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    // Bus handshake: bus_req is held with stable addr/we/be/wdata until the
    // first cycle in which bus_ready is high; that cycle completes the access
    // and, for reads, bus_rdata is valid in that same cycle.

    state_t         state, next_state;
    logic           is_write;
    logic [1:0]     addr_lo;
    logic [2:0]     size_q;
    logic [CW-1:0]  wait_cnt;
    logic           legal;
    logic           timed_out;
    logic [3:0]     be_c;
    logic [31:0]    wdata_c;
    logic [31:0]    load_data;

    assign dbg_state = state;
    assign legal     = access_legal(mem_size, mem_addr[1:0], is_write);
    assign timed_out = (wait_cnt == CW'(TIMEOUT));

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (mem_read || mem_write) next_state = S_CAPTURE;
            S_CAPTURE: next_state = legal ? S_REQ : S_RESP;
            S_REQ:     if (bus_ready || timed_out) next_state = S_RESP;
            S_RESP:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = mem_wdata;
        case (mem_size_t'(mem_size))
            MEM_B, MEM_BU: begin
                be_c    = 4'b0001 << mem_addr[1:0];
                wdata_c = {4{mem_wdata[7:0]}};
            end
            MEM_H, MEM_HU: begin
                be_c    = mem_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{mem_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    mem_lane_align u_lane_align (
        .rdata   (bus_rdata),
        .addr_lo (addr_lo),
        .size    (size_q),
        .data    (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            is_write  <= 1'b0;
            addr_lo   <= 2'b00;
            size_q    <= 3'b000;
            wait_cnt  <= '0;
            mem_resp  <= 1'b0;
            mem_err   <= 1'b0;
            mem_rdata <= 32'd0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
        end else begin
            state    <= next_state;
            bus_req  <= (next_state == S_REQ);
            mem_resp <= (next_state == S_RESP);
            mem_err  <= ((state == S_CAPTURE) && !legal) ||
                        ((state == S_REQ) && !bus_ready && timed_out);
            case (state)
                S_IDLE: begin
                    if (mem_read || mem_write) is_write <= mem_write;
                end
                // MAR may be loaded in the pulse cycle, so sample one cycle later.
                S_CAPTURE: begin
                    addr_lo  <= mem_addr[1:0];
                    size_q   <= mem_size;
                    wait_cnt <= '0;
                    if (legal) begin
                        bus_we    <= is_write;
                        bus_addr  <= {mem_addr[31:2], 2'b00};
                        bus_be    <= be_c;
                        bus_wdata <= is_write ? wdata_c : 32'd0;
                    end
                end
                S_REQ: begin
                    if (bus_ready) begin
                        if (!is_write) mem_rdata <= load_data;
                    end else if (!timed_out) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge: directed loads/stores, alignment errors,
// bus timeout and mid-access reset, plus a short random load run.
module tb_mem_bridge;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [2:0]  mem_size = 3'd0;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic [1:0]  dbg_state;

    mem_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_size  (mem_size),
        .mem_resp  (mem_resp),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [32:0] exp_q[$];        // {err, rdata} expected at each mem_resp
    logic [31:0] last_rd = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Reference load extraction, written with shifts rather than lane muxes.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] lo,
                                             input logic [2:0] sz);
        logic signed [31:0] s;
        int l;
        l = int'(lo);
        case (sz)
            3'b000: begin s = signed'(w << (8 * (3 - l)));    return 32'(s >>> 24); end
            3'b001: begin s = signed'(w << (16 * (1 - l / 2))); return 32'(s >>> 16); end
            3'b100: return (w >> (8 * l)) & 32'h0000_00FF;
            3'b101: return (w >> (16 * (l / 2))) & 32'h0000_FFFF;
            default: return w;
        endcase
    endfunction

    // driver: one access, acting as bus responder; ready_at = index of the
    // REQ cycle in which bus_ready is raised (0 = never).
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] size, input int ready_at,
                          input logic [31:0] rword, input logic exp_err,
                          input logic [31:0] exp_rd, input int exp_lat,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
        int lat;
        int req_n;
        bit done;
        logic [32:0] e;
        if (!exp_err && !wr) last_rd = exp_rd;
        exp_q.push_back({exp_err, last_rd});
        @(negedge clk);
        mem_read = rd; mem_write = wr;
        mem_addr = ~addr; mem_wdata = ~wdata; mem_size = ~size;
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        mem_addr = addr; mem_wdata = wdata; mem_size = size;
        lat = 1; req_n = 0; done = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            mem_addr  = $urandom;
            mem_wdata = $urandom;
            mem_size  = 3'($urandom_range(0, 7));
            bus_ready = 1'b0;
            bus_rdata = $urandom;
            if (bus_req) begin
                req_n++;
                if (req_n == 1) begin
                    check({tag, " bus_addr"}, bus_addr, {addr[31:2], 2'b00});
                    check({tag, " bus_be"}, 32'(bus_be), 32'(exp_be));
                    check({tag, " bus_we"}, 32'(bus_we), 32'(wr));
                    if (wr) check({tag, " bus_wdata"}, bus_wdata, exp_wd);
                end
                if (req_n == ready_at) begin
                    bus_ready = 1'b1;
                    bus_rdata = rword;
                end
            end
            if (mem_resp) begin
                done = 1'b1;
                if (exp_q.size() == 0) begin
                    check({tag, " unexpected resp"}, 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
                    check({tag, " req cycles"}, 32'(req_n), 32'(exp_lat - 2));
                    check({tag, " mem_err"}, 32'(mem_err), 32'(e[32]));
                    check({tag, " mem_rdata"}, mem_rdata, e[31:0]);
                end
            end
        end
        bus_ready = 1'b0;
        if (!done) check({tag, " no mem_resp"}, 32'd0, 32'd1);
        @(negedge clk);
        check({tag, " resp one cycle"}, 32'(mem_resp), 32'd0);
        check({tag, " rdata held"}, mem_rdata, last_rd);
    endtask

    initial begin
        logic [2:0]  sz;
        logic [1:0]  lo;
        logic [31:0] a;
        logic [31:0] w;
        int          rdy;
        logic [2:0]  sizes[5];
        sizes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst mem_resp", 32'(mem_resp), 32'd0);
        check("rst mem_err", 32'(mem_err), 32'd0);
        check("rst bus_req", 32'(bus_req), 32'd0);
        check("rst bus_we", 32'(bus_we), 32'd0);
        check("rst bus_addr", bus_addr, 32'd0);
        check("rst bus_be", 32'(bus_be), 32'd0);
        check("rst bus_wdata", bus_wdata, 32'd0);
        check("rst mem_rdata", mem_rdata, 32'd0);
        check("rst state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;

        access("LW 0x100", 1, 0, 32'h100, 0, 3'b010, 1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 3, 4'b1111, 0);
        access("LB 0x103", 1, 0, 32'h103, 0, 3'b000, 1, 32'h80FF0000, 0, 32'hFFFFFF80, 3, 4'b1000, 0);
        access("LBU 0x103", 1, 0, 32'h103, 0, 3'b100, 1, 32'h80FF0000, 0, 32'h00000080, 3, 4'b1000, 0);
        access("SH 0x202", 0, 1, 32'h202, 32'h1234ABCD, 3'b001, 1, 0, 0, 0, 3, 4'b1100, 32'hABCDABCD);
        access("SB 0x501", 0, 1, 32'h501, 32'h000000AB, 3'b000, 2, 0, 0, 0, 4, 4'b0010, 32'hABABABAB);
        access("LH 0x102", 1, 0, 32'h102, 0, 3'b001, 2, 32'h8001_7FFF, 0, 32'hFFFF8001, 4, 4'b1100, 0);
        access("LHU 0x100", 1, 0, 32'h100, 0, 3'b101, 1, 32'h0000_F00D, 0, 32'h0000F00D, 3, 4'b0011, 0);

        access("LW 0x101 misaligned", 1, 0, 32'h101, 0, 3'b010, 1, 0, 1, 0, 2, 0, 0);
        access("SW 0x302 misaligned", 0, 1, 32'h302, 32'h55, 3'b010, 1, 0, 1, 0, 2, 0, 0);
        access("LH 0x103 misaligned", 1, 0, 32'h103, 0, 3'b001, 1, 0, 1, 0, 2, 0, 0);
        access("SBU illegal", 0, 1, 32'h300, 32'h55, 3'b100, 1, 0, 1, 0, 2, 0, 0);
        access("size 011 illegal", 1, 0, 32'h300, 0, 3'b011, 1, 0, 1, 0, 2, 0, 0);

        access("LW timeout", 1, 0, 32'h400, 0, 3'b010, 0, 0, 1, 0, 2 + TIMEOUT + 1, 4'b1111, 0);
        access("LW ready 4th", 1, 0, 32'h400, 0, 3'b010, 4, 32'h0BADF00D, 0, 32'h0BADF00D, 6, 4'b1111, 0);
        access("LW ready at limit", 1, 0, 32'h404, 0, 3'b010, TIMEOUT + 1, 32'h13579BDF, 0,
               32'h13579BDF, 2 + TIMEOUT + 1, 4'b1111, 0);
        access("read+write both", 1, 1, 32'h500, 32'h11223344, 3'b010, 1, 0, 0, 0, 3, 4'b1111, 32'h11223344);

        // reset while the bus request is outstanding
        @(negedge clk);
        mem_read = 1'b1; mem_addr = 32'h600; mem_size = 3'b010;
        @(negedge clk);
        mem_read = 1'b0;
        @(negedge clk);
        check("mid-reset req up", 32'(bus_req), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        mem_read = 1'b1;
        @(negedge clk);
        check("mid-reset bus_req", 32'(bus_req), 32'd0);
        check("mid-reset state", 32'(dbg_state), 32'd0);
        check("mid-reset mem_rdata", mem_rdata, 32'd0);
        mem_read = 1'b0;
        rst_n = 1'b1;
        last_rd = 32'd0;
        repeat (3) @(negedge clk);
        check("lost pulse state", 32'(dbg_state), 32'd0);
        check("lost pulse resp", 32'(mem_resp), 32'd0);
        access("LW after reset", 1, 0, 32'h700, 0, 3'b010, 1, 32'hCAFEF00D, 0, 32'hCAFEF00D, 3, 4'b1111, 0);

        // random legal loads
        for (int i = 0; i < 10; i++) begin
            sz  = sizes[$urandom_range(0, 4)];
            lo  = 2'($urandom_range(0, 3));
            if (sz == 3'b001 || sz == 3'b101) lo[0] = 1'b0;
            if (sz == 3'b010) lo = 2'b00;
            a   = {20'h0, 10'($urandom_range(0, 1023)), lo};
            w   = $urandom;
            rdy = $urandom_range(1, 3);
            access("rand load", 1, 0, a, 0, sz, rdy, w, 0, ref_load(w, lo, sz), 2 + rdy,
                   (sz == 3'b010) ? 4'b1111 :
                   (sz == 3'b001 || sz == 3'b101) ? (lo[1] ? 4'b1100 : 4'b0011) :
                   (4'b0001 << lo), 0);
        end

        check("queue drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
